// File: rtl/modn_pkg.sv
// Shared types and constants for the programmable modulus counter family.
//   dir_e   : count direction (DIR_UP / DIR_DOWN)
//   MIN_MOD : smallest legal modulus
package modn_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int MIN_MOD = 2;

endpackage : modn_pkg

// File: rtl/prog_mod_n_counter.sv
// Runtime-programmable modulus counter (up/down, modulo 2..MAX_N).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   enable    : advance the count this cycle
//   dir       : 0 = up, 1 = down (modn_pkg::dir_e)
//   clear     : synchronous clear of count, tc, wrap_cnt, err
//   load      : load load_val into count
//   load_val  : value to load (must be < modulus)
//   mod_wr    : write mod_in as the new modulus
//   mod_in    : new modulus (MIN_MOD..MAX_N)
//   count     : current count, always < modulus
//   modulus   : active modulus
//   tc        : one-cycle pulse on the cycle after each wrap edge
//   wrap_cnt  : wraps since reset/clear, saturating at all-ones
//   err       : sticky flag for illegal mod_wr / load, cleared by clear
// Per-cycle priority: clear > mod_wr > load > enable.
module prog_mod_n_counter
    import modn_pkg::*;
#(
    parameter int MAX_N     = 16,
    parameter int DEFAULT_N = 10,
    parameter int CW        = $clog2(MAX_N),
    parameter int MW        = $clog2(MAX_N + 1),
    parameter int WRAP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              dir,
    input  logic              clear,
    input  logic              load,
    input  logic [CW-1:0]     load_val,
    input  logic              mod_wr,
    input  logic [MW-1:0]     mod_in,
    output logic [CW-1:0]     count,
    output logic [MW-1:0]     modulus,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err
);

    logic [CW-1:0]     r_count;
    logic [MW-1:0]     r_modulus;
    logic              r_tc;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_err;

    logic [CW-1:0]     w_count_nxt;
    logic [MW-1:0]     w_modulus_nxt;
    logic              w_tc_nxt;
    logic [WRAP_W-1:0] w_wrap_cnt_nxt;
    logic              w_err_nxt;

    logic [MW-1:0]     w_mod_m1;
    logic              w_at_top;
    logic              w_at_zero;
    logic              w_mod_legal;
    logic              w_load_legal;
    logic              w_wrap;

    // Decode helpers; modulus-1 is formed in MW bits so a modulus of MAX_N
    // never overflows and the down-wrap never underflows the count.
    always_comb begin
        w_mod_m1     = r_modulus - MW'(1);
        w_at_top     = (MW'(r_count) == w_mod_m1);
        w_at_zero    = (r_count == {CW{1'b0}});
        w_mod_legal  = (mod_in >= MW'(MIN_MOD)) && (mod_in <= MW'(MAX_N));
        w_load_legal = (MW'(load_val) < r_modulus);
    end

    // Next-state selection in priority order; tc defaults low so it only
    // survives one cycle after a wrap.
    always_comb begin
        w_count_nxt    = r_count;
        w_modulus_nxt  = r_modulus;
        w_tc_nxt       = 1'b0;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_err_nxt      = r_err;
        w_wrap         = 1'b0;

        if (clear) begin
            w_count_nxt    = {CW{1'b0}};
            w_wrap_cnt_nxt = {WRAP_W{1'b0}};
            w_err_nxt      = 1'b0;
        end else if (mod_wr) begin
            // An illegal write still owns the cycle: load/enable are dropped.
            if (w_mod_legal) begin
                w_modulus_nxt = mod_in;
                w_count_nxt   = {CW{1'b0}};
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (load) begin
            if (w_load_legal) begin
                w_count_nxt = load_val;
            end else begin
                w_count_nxt = {CW{1'b0}};
                w_err_nxt   = 1'b1;
            end
        end else if (enable) begin
            if (dir_e'(dir) == DIR_DOWN) begin
                if (w_at_zero) begin
                    w_count_nxt = CW'(w_mod_m1);
                    w_wrap      = 1'b1;
                end else begin
                    w_count_nxt = r_count - CW'(1);
                end
            end else begin
                if (w_at_top) begin
                    w_count_nxt = {CW{1'b0}};
                    w_wrap      = 1'b1;
                end else begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
        end else begin
            w_count_nxt = r_count;
        end

        if (w_wrap) begin
            w_tc_nxt = 1'b1;
            if (r_wrap_cnt != {WRAP_W{1'b1}}) begin
                w_wrap_cnt_nxt = r_wrap_cnt + WRAP_W'(1);
            end else begin
                w_wrap_cnt_nxt = r_wrap_cnt;
            end
        end else begin
            w_tc_nxt = 1'b0;
        end
    end

    // Count and modulus state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= {CW{1'b0}};
            r_modulus <= MW'(DEFAULT_N);
        end else begin
            r_count   <= w_count_nxt;
            r_modulus <= w_modulus_nxt;
        end
    end

    // Terminal-count pulse and saturating wrap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tc       <= 1'b0;
            r_wrap_cnt <= {WRAP_W{1'b0}};
        end else begin
            r_tc       <= w_tc_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign count    = r_count;
    assign modulus  = r_modulus;
    assign tc       = r_tc;
    assign wrap_cnt = r_wrap_cnt;
    assign err      = r_err;

endmodule : prog_mod_n_counter

// File: tb/tb_prog_mod_n_counter.sv
// Self-checking bench for prog_mod_n_counter. A default instance (WRAP_W=8)
// and a WRAP_W=2 instance share all inputs; the narrow one is checked for
// wrap_cnt saturation at 3.
module tb_prog_mod_n_counter;

    localparam int CW = 4;
    localparam int MW = 5;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          dir;
    logic          clear;
    logic          load;
    logic [CW-1:0] load_val;
    logic          mod_wr;
    logic [MW-1:0] mod_in;

    logic [CW-1:0] count;
    logic [MW-1:0] modulus;
    logic          tc;
    logic [7:0]    wrap_cnt;
    logic          err;

    logic [CW-1:0] count2;
    logic [MW-1:0] modulus2;
    logic          tc2;
    logic [1:0]    wrap_cnt2;
    logic          err2;

    int n_vec;
    int n_miscmp;

    typedef struct {
        logic          enable;
        logic          dir;
        logic          clear;
        logic          load;
        logic [CW-1:0] load_val;
        logic          mod_wr;
        logic [MW-1:0] mod_in;
        logic [CW-1:0] e_count;
        logic [MW-1:0] e_mod;
        logic          e_tc;
        logic [7:0]    e_wrap;
        logic          e_err;
    } vec_t;

    typedef struct {
        logic [CW-1:0] count;
        logic [MW-1:0] modulus;
        logic          tc;
        logic [7:0]    wrap;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[35];

    prog_mod_n_counter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .dir      (dir),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_in   (mod_in),
        .count    (count),
        .modulus  (modulus),
        .tc       (tc),
        .wrap_cnt (wrap_cnt),
        .err      (err)
    );

    prog_mod_n_counter #(.WRAP_W(2)) u_dut_w2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .dir      (dir),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_in   (mod_in),
        .count    (count2),
        .modulus  (modulus2),
        .tc       (tc2),
        .wrap_cnt (wrap_cnt2),
        .err      (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count < modulus must hold whenever the counter is out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            assert ({1'b0, count} < modulus)
            else begin
                n_miscmp++;
                $display("FAIL invariant: count=%0d modulus=%0d", count, modulus);
            end
        end
    end

    function automatic vec_t mk(input logic en, input logic dr, input logic cl,
                                input logic ld, input int lv, input logic mw,
                                input int mi, input int c, input int m,
                                input logic t, input int w, input logic e);
        vec_t v;
        v.enable   = en;
        v.dir      = dr;
        v.clear    = cl;
        v.load     = ld;
        v.load_val = 4'(lv);
        v.mod_wr   = mw;
        v.mod_in   = 5'(mi);
        v.e_count  = 4'(c);
        v.e_mod    = 5'(m);
        v.e_tc     = t;
        v.e_wrap   = 8'(w);
        v.e_err    = e;
        return v;
    endfunction

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s %s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        logic [1:0] e_w2;
        e = sb_q.pop_front();
        e_w2 = (e.wrap > 8'd3) ? 2'd3 : e.wrap[1:0];
        n_vec++;
        cmp(name, "count",    32'(count),     32'(e.count));
        cmp(name, "modulus",  32'(modulus),   32'(e.modulus));
        cmp(name, "tc",       32'(tc),        32'(e.tc));
        cmp(name, "wrap_cnt", 32'(wrap_cnt),  32'(e.wrap));
        cmp(name, "err",      32'(err),       32'(e.err));
        cmp(name, "wrap_w2",  32'(wrap_cnt2), 32'(e_w2));
        cmp(name, "count_w2", 32'(count2),    32'(e.count));
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.count   = v.e_count;
        e.modulus = v.e_mod;
        e.tc      = v.e_tc;
        e.wrap    = v.e_wrap;
        e.err     = v.e_err;
        sb_q.push_back(e);
    endtask

    // Drive at the falling edge, let one rising edge act, check at the next falling edge.
    task automatic apply(input vec_t v, input string name);
        enable   = v.enable;
        dir      = v.dir;
        clear    = v.clear;
        load     = v.load;
        load_val = v.load_val;
        mod_wr   = v.mod_wr;
        mod_in   = v.mod_in;
        push_exp(v);
        @(posedge clk);
        @(negedge clk);
        check_pop(name);
    endtask

    task automatic idle_inputs();
        enable   = 1'b0;
        dir      = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        mod_wr   = 1'b0;
        mod_in   = 5'd0;
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;

        //              en dir clr ld lv mw mi   cnt mod tc wrap err
        tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0,   5,  10, 0, 2, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0,  0, 0,   6,  10, 0, 2, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0,  0, 0,   7,  10, 0, 2, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0,  1, 4,   0,  4,  0, 2, 0); // mod_wr beats enable
        tbl[4]  = mk(1, 0, 0, 0, 0,  0, 0,   1,  4,  0, 2, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0,  0, 0,   2,  4,  0, 2, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0,  0, 0,   3,  4,  0, 2, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0,  0, 0,   0,  4,  1, 3, 0); // 3->0 wrap
        tbl[8]  = mk(1, 0, 0, 0, 0,  0, 0,   1,  4,  0, 3, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,  1, 10,  0,  10, 0, 3, 0);
        tbl[10] = mk(1, 1, 0, 0, 0,  0, 0,   9,  10, 1, 4, 0); // down 0->9 wrap
        tbl[11] = mk(1, 1, 0, 0, 0,  0, 0,   8,  10, 0, 4, 0);
        tbl[12] = mk(1, 1, 0, 0, 0,  0, 0,   7,  10, 0, 4, 0);
        tbl[13] = mk(1, 0, 0, 0, 0,  0, 0,   8,  10, 0, 4, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,  0, 0,   8,  10, 0, 4, 0); // hold
        tbl[15] = mk(0, 0, 0, 0, 0,  1, 1,   8,  10, 0, 4, 1); // mod 1 illegal
        tbl[16] = mk(1, 0, 0, 0, 0,  0, 0,   9,  10, 0, 4, 1);
        tbl[17] = mk(0, 0, 0, 0, 0,  1, 17,  9,  10, 0, 4, 1); // mod 17 illegal
        tbl[18] = mk(0, 0, 0, 0, 0,  1, 0,   9,  10, 0, 4, 1); // mod 0 illegal
        tbl[19] = mk(1, 0, 0, 0, 0,  0, 0,   0,  10, 1, 5, 1); // err sticky
        tbl[20] = mk(1, 0, 1, 0, 0,  0, 0,   0,  10, 0, 0, 0); // clear wins
        tbl[21] = mk(1, 0, 0, 0, 0,  0, 0,   1,  10, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 12, 0, 0,   0,  10, 0, 0, 1); // load 12 illegal
        tbl[23] = mk(0, 0, 1, 0, 0,  0, 0,   0,  10, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 1, 9,  0, 0,   9,  10, 0, 0, 0);
        tbl[25] = mk(1, 0, 0, 1, 3,  0, 0,   3,  10, 0, 0, 0); // load beats enable
        tbl[26] = mk(0, 0, 0, 1, 9,  0, 0,   9,  10, 0, 0, 0);
        tbl[27] = mk(0, 0, 0, 1, 10, 0, 0,   0,  10, 0, 0, 1); // load == modulus
        tbl[28] = mk(0, 0, 1, 0, 0,  0, 0,   0,  10, 0, 0, 0);
        tbl[29] = mk(0, 0, 0, 0, 0,  1, 16,  0,  16, 0, 0, 0); // mod = MAX_N
        tbl[30] = mk(0, 0, 0, 1, 15, 0, 0,   15, 16, 0, 0, 0);
        tbl[31] = mk(1, 0, 0, 0, 0,  0, 0,   0,  16, 1, 1, 0);
        tbl[32] = mk(1, 1, 0, 0, 0,  0, 0,   15, 16, 1, 2, 0); // back-to-back wrap
        tbl[33] = mk(1, 1, 0, 0, 0,  0, 0,   14, 16, 0, 2, 0);
        tbl[34] = mk(0, 0, 1, 0, 0,  1, 5,   0,  16, 0, 0, 0); // clear beats mod_wr

        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        push_exp(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0));
        check_pop("reset_async");
        @(negedge clk);
        rst_n = 1'b1;

        // Count up 24 edges from reset: 1..9,0..9,0..4, wraps after edges 10 and 20.
        for (int i = 1; i <= 24; i++) begin
            apply(mk(1, 0, 0, 0, 0, 0, 0, i % 10, 10, ((i % 10) == 0), i / 10, 0),
                  $sformatf("up%0d", i));
        end

        for (int i = 0; i < 35; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Modulus 2 with dir alternating so every edge wraps: tc stays high,
        // narrow wrap counter saturates at 3.
        apply(mk(0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0, 0), "mod2_wr");
        for (int k = 1; k <= 12; k++) begin
            apply(mk(1, (k % 2) == 1, 0, 0, 0, 0, 0, (k % 2), 2, 1, k, 0),
                  $sformatf("mod2_wrap%0d", k));
        end
        apply(mk(0, 0, 0, 0, 0, 1, 17, 0, 2, 0, 12, 1), "mod2_err");

        // Reset asserted away from any clock edge.
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        push_exp(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0));
        check_pop("rst_mid");
        @(posedge clk);
        #1;
        push_exp(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0));
        check_pop("rst_hold");
        #3 rst_n = 1'b1;
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0), "post_rst1");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 2, 10, 0, 0, 0), "post_rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule : tb_prog_mod_n_counter
